uart16550_tx_fifo: RTL

//  Transmit Holding Register / Tx FIFO feeding the UART16550 transmitter.

---
 rtl/uart16550_pkg.sv | 16 +
 rtl/uart16550_fifo.sv | 82 ++++++++
 rtl/uart16550_tx_fifo.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart16550_pkg.sv
// Shared UART16550 definitions.
//   fcr_t         : FIFO Control Register layout (bit 7 down to bit 0)
//   TX_FIFO_DEPTH : Tx FIFO entries in 16550 mode
package uart16550_pkg;

    typedef struct packed {
        logic [1:0] rx_trigger;   // FCR[7:6] Rx FIFO trigger level
        logic [2:0] rsvd;         // FCR[5:3] unused here (DMA mode / reserved)
        logic       tx_clr;       // FCR[2]   Tx FIFO reset
        logic       rx_clr;       // FCR[1]   Rx FIFO reset
        logic       fifo_en;      // FCR[0]   FIFO enable
    } fcr_t;

    localparam int TX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart16550_fifo.sv
// Generic synchronous FIFO with first-word-fall-through read, shared by the
// UART Tx and Rx paths. The usable capacity is a run-time input so a single
// array can act as a 1-entry holding register or as a full FIFO.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clr_i          empties the FIFO; wins over a same-cycle push/pop
//   push_i, d_i    write request and data
//   pop_i          read request; q_o is the oldest entry
//   cap_i          current capacity (1..DEPTH)
//   count_o        number of stored entries
//   empty_o/full_o status
//   push_acc_o     push taken this cycle
//   pop_acc_o      pop taken this cycle
module uart16550_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [DW-1:0] d_i,
    input  logic          pop_i,
    input  logic [CW-1:0] cap_i,
    output logic [DW-1:0] q_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          push_acc_o,
    output logic          pop_acc_o
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    assign empty_o = (r_count == '0);
    // >= rather than == so a capacity drop with entries still stored never
    // looks like free space before the accompanying clear lands.
    assign full_o  = (r_count >= cap_i);

    assign pop_acc_o  = pop_i & !empty_o & !clr_i;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign push_acc_o = push_i & !clr_i & (!full_o | pop_acc_o);

    assign q_o     = r_mem[r_rd_ptr];
    assign count_o = r_count;

    always_ff @(posedge clk_i) begin
        if (push_acc_o) begin
            r_mem[r_wr_ptr] <= d_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_acc_o) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (pop_acc_o) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({push_acc_o, pop_acc_o})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart16550_tx_fifo.sv
// UART16550 Transmit Holding Register / Tx FIFO.
// Holds bytes written to THR and presents the oldest one to the transmitter
// (first-word-fall-through). Acts as a 1-byte THR when fifo_en_i=0 and as a
// DEPTH-byte FIFO when fifo_en_i=1; any mode change empties it. Also produces
// LSR.THRE (empty_o), LSR.TEMT (temt_o) and the THRE interrupt.
// Optional feature macro: UART16550_TX_FIFO_LEVEL_EN adds level_o (fill
// level) and ovr_o (sticky "push while full" flag).
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   fifo_en_i, clr_i   FCR[0] mode, FCR[2] Tx FIFO reset pulse
//   push_i, d_i        THR write
//   pop_i, q_o         transmitter read / oldest byte
//   empty_o, full_o    status
//   sr_empty_i, temt_o shift register empty in, TEMT out
//   etbei_i, iir_rd_i  interrupt enable, IIR read acknowledging THRE
//   thre_irq_o         THRE interrupt pending
module uart16550_tx_fifo
    import uart16550_pkg::*;
#(
    parameter int DEPTH = TX_FIFO_DEPTH,
    parameter int DW    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   fifo_en_i,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic [DW-1:0]          d_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          q_o,
    output logic                   empty_o,
    output logic                   full_o,
    input  logic                   sr_empty_i,
    output logic                   temt_o,
    input  logic                   etbei_i,
    input  logic                   iir_rd_i,
    output logic                   thre_irq_o
`ifdef UART16550_TX_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   ovr_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          r_fifo_en;
    logic          r_etbei;
    logic          r_thre_pend;

    logic          w_mode_chg;
    logic          w_clr;
    logic [CW-1:0] w_cap;
    logic [CW-1:0] w_count;
    logic          w_push_acc;
    logic          w_pop_acc;
    logic          w_going_empty;
    logic          w_etbei_rise;

    assign w_mode_chg = (fifo_en_i != r_fifo_en);
    assign w_clr      = clr_i | w_mode_chg;
    assign w_cap      = fifo_en_i ? CW'(DEPTH) : CW'(1);

    uart16550_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (w_clr),
        .push_i     (push_i),
        .d_i        (d_i),
        .pop_i      (pop_i),
        .cap_i      (w_cap),
        .q_o        (q_o),
        .count_o    (w_count),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .push_acc_o (w_push_acc),
        .pop_acc_o  (w_pop_acc)
    );

    assign temt_o = empty_o & sr_empty_i;

    // Non-empty -> empty: a clear, or popping the last entry with no refill.
    assign w_going_empty = !empty_o &
                           (w_clr | (w_pop_acc & !w_push_acc & (w_count == CW'(1))));
    assign w_etbei_rise  = etbei_i & !r_etbei & empty_o;

    // An accepted push leaves the FIFO non-empty, so it always cancels THRE;
    // otherwise a new set condition beats the IIR-read acknowledge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fifo_en   <= 1'b0;
            r_etbei     <= 1'b0;
            r_thre_pend <= 1'b0;
        end else begin
            r_fifo_en <= fifo_en_i;
            r_etbei   <= etbei_i;
            if (w_push_acc) begin
                r_thre_pend <= 1'b0;
            end else if (w_going_empty | w_etbei_rise) begin
                r_thre_pend <= 1'b1;
            end else if (iir_rd_i) begin
                r_thre_pend <= 1'b0;
            end
        end
    end

    assign thre_irq_o = r_thre_pend & etbei_i;

`ifdef UART16550_TX_FIFO_LEVEL_EN
    logic r_ovr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovr <= 1'b0;
        end else if (w_clr) begin
            r_ovr <= 1'b0;
        end else if (push_i & !w_push_acc) begin
            r_ovr <= 1'b1;
        end
    end

    assign level_o = w_count;
    assign ovr_o   = r_ovr;
`endif

endmodule
